seg7_count_monitor: RTL and testbench

SEG7_COUNT_MONITOR -- requirements
Module: seg7_count_monitor

---
 rtl/seg7_pkg.sv | 46 ++++
 rtl/seg7_to_bin.sv | 31 +++
 rtl/seg7_count_monitor.sv | 127 ++++++++++++
 tb/tb_seg7_count_monitor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seven-segment count monitor:
//   - the eight common-anode (active-low) segment patterns, bit6..bit0 = g..a
//   - the monitor FSM state encoding
//   - small helpers for successor arithmetic and the saturating error counter
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // IDLE   : nothing decoded yet (or the last sample was garbage)
  // TRACK  : a previous value is held and a run of correct steps is counted
  // LOCKED : enough consecutive correct steps seen; deviations are errors
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next value in the expected count sequence. The 3-bit result wraps
  // naturally, so 0->7 (down) and 7->0 (up) fall out of the arithmetic.
  function automatic logic [2:0] next_value(input logic [2:0] prev,
                                            input logic       down);
    logic [2:0] nxt;
    if (down) nxt = prev - 3'd1;
    else      nxt = prev + 3'd1;
    return nxt;
  endfunction

  // Error counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    logic [7:0] res;
    if (cnt == ERR_CNT_MAX) res = cnt;
    else                    res = cnt + 8'd1;
    return res;
  endfunction

endpackage

// File: rtl/seg7_to_bin.sv
// seg7_to_bin
// Purely combinational lookup from a seven-segment pattern to its digit.
// Ports:
//   seg  in  7  segment pattern, active-low, bit6..bit0 = g..a
//   val  out 3  decoded value (0 when the pattern is not recognised)
//   ok   out 1  high when seg matches one of the eight known patterns
module seg7_to_bin
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [2:0] val,
  output logic       ok
);

  always_comb begin
    val = 3'd0;
    ok  = 1'b1;
    case (seg)
      SEG_0:   val = 3'd0;
      SEG_1:   val = 3'd1;
      SEG_2:   val = 3'd2;
      SEG_3:   val = 3'd3;
      SEG_4:   val = 3'd4;
      SEG_5:   val = 3'd5;
      SEG_6:   val = 3'd6;
      SEG_7:   val = 3'd7;
      default: ok  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_count_monitor.sv
// seg7_count_monitor
// Watches a strobed seven-segment display feed and checks that it counts
// in the expected direction (DOWN=1: 7,6,..,0,7; DOWN=0: 0,1,..,7,0).
// After LOCK_N consecutive correct steps the monitor locks; while locked,
// any out-of-sequence digit is flagged as a sequence error.
// Parameters:
//   DOWN      expected count direction (1 = down, 0 = up)
//   LOCK_N    consecutive correct transitions needed to lock (1..7)
// Ports:
//   clk        in  1  system clock, rising edge
//   reset      in  1  synchronous active-high reset
//   seg_in     in  7  segment pattern, sampled only when seg_stb=1
//   seg_stb    in  1  one-cycle sample strobe
//   digit      out 3  last successfully decoded value
//   digit_vld  out 1  pulse: a good code was decoded
//   bad_code   out 1  pulse: sampled pattern not in the code table
//   seq_err    out 1  pulse: locked and the digit is not the expected successor
//   locked     out 1  high while in LOCKED
//   err_cnt    out 8  saturating count of bad_code + seq_err events
module seg7_count_monitor
  import seg7_pkg::*;
#(
  parameter bit DOWN   = 1'b1,
  parameter int LOCK_N = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  input  logic       seg_stb,
  output logic [2:0] digit,
  output logic       digit_vld,
  output logic       bad_code,
  output logic       seq_err,
  output logic       locked,
  output logic [7:0] err_cnt
);

  // run never exceeds LOCK_N-1 <= 6, so run+1 always fits in 3 bits.
  localparam logic [2:0] LOCK_TARGET = 3'(LOCK_N);

  state_t     state;
  logic [2:0] prev;
  logic [2:0] run;

  logic [2:0] dec_val;
  logic       dec_ok;
  logic       is_succ;

  seg7_to_bin u_dec (
    .seg (seg_in),
    .val (dec_val),
    .ok  (dec_ok)
  );

  assign is_succ = (dec_val == next_value(prev, DOWN));

  // Monitor FSM. Pulse outputs default low every cycle so they last exactly
  // one cycle after a strobe; digit, locked and err_cnt only move when a
  // strobe is accepted. A bad pattern wipes the history (back to IDLE) but
  // leaves digit and prev untouched since nothing valid was seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      prev      <= 3'd0;
      run       <= 3'd0;
      digit     <= 3'd0;
      digit_vld <= 1'b0;
      bad_code  <= 1'b0;
      seq_err   <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      digit_vld <= 1'b0;
      bad_code  <= 1'b0;
      seq_err   <= 1'b0;
      if (seg_stb) begin
        if (!dec_ok) begin
          bad_code <= 1'b1;
          err_cnt  <= sat_inc(err_cnt);
          state    <= ST_IDLE;
          locked   <= 1'b0;
          run      <= 3'd0;
        end else begin
          digit_vld <= 1'b1;
          digit     <= dec_val;
          prev      <= dec_val;
          case (state)
            ST_IDLE: begin
              run    <= 3'd0;
              state  <= ST_TRACK;
              locked <= 1'b0;
            end
            ST_TRACK: begin
              if (is_succ) begin
                if (run + 3'd1 == LOCK_TARGET) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                  run    <= 3'd0;
                end else begin
                  run <= run + 3'd1;
                end
              end else begin
                // A fresh starting point, not an error: just restart the run.
                run <= 3'd0;
              end
            end
            ST_LOCKED: begin
              if (!is_succ) begin
                seq_err <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                state   <= ST_TRACK;
                locked  <= 1'b0;
                run     <= 3'd0;
              end
            end
            default: begin
              state  <= ST_IDLE;
              locked <= 1'b0;
              run    <= 3'd0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_count_monitor.sv
// tb_seg7_count_monitor
// Drives two monitor instances from the same stimulus: instance 0 counts
// down with LOCK_N=2, instance 1 counts up with LOCK_N=1. A hand-written
// vector table checks instance 0 against precomputed values, a behavioural
// model checks both instances every cycle, and directed sequences cover
// counter saturation and the up-count wrap.
module tb_seg7_count_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg_in;
  logic       seg_stb;

  logic [2:0] digit     [2];
  logic       digit_vld [2];
  logic       bad_code  [2];
  logic       seq_err   [2];
  logic       locked    [2];
  logic [7:0] err_cnt   [2];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seg7_count_monitor #(.DOWN(1'b1), .LOCK_N(2)) dut_down (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .seg_stb   (seg_stb),
    .digit     (digit[0]),
    .digit_vld (digit_vld[0]),
    .bad_code  (bad_code[0]),
    .seq_err   (seq_err[0]),
    .locked    (locked[0]),
    .err_cnt   (err_cnt[0])
  );

  seg7_count_monitor #(.DOWN(1'b0), .LOCK_N(1)) dut_up (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .seg_stb   (seg_stb),
    .digit     (digit[1]),
    .digit_vld (digit_vld[1]),
    .bad_code  (bad_code[1]),
    .seq_err   (seq_err[1]),
    .locked    (locked[1]),
    .err_cnt   (err_cnt[1])
  );

  logic [6:0] codeTab [8];

  // Reference model state, tracked in plain integers.
  typedef struct {
    int hasPrev;
    int prev;
    int streak;
    int isLocked;
    int dig;
    int vld;
    int bad;
    int seq;
    int err;
  } model_t;

  model_t mdl [2];
  int     mdlDown  [2];
  int     mdlLockN [2];

  typedef struct {
    logic [6:0] seg;
    logic       stb;
    logic       rst;
    logic [2:0] dig;
    logic       vld;
    logic       bad;
    logic       seq;
    logic       lck;
    logic [7:0] err;
  } vec_t;

  vec_t vecs [$];

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int decodeValue(input logic [6:0] s);
    int v = -1;
    for (int k = 0; k < 8; k++)
      if (codeTab[k] == s) v = k;
    return v;
  endfunction

  task automatic updateModel(input int i, input logic [6:0] s, input logic stb,
                             input logic rst);
    int v;
    int expNext;
    if (rst) begin
      mdl[i] = '{default: 0};
    end else begin
      mdl[i].vld = 0;
      mdl[i].bad = 0;
      mdl[i].seq = 0;
      if (stb) begin
        v = decodeValue(s);
        if (v < 0) begin
          mdl[i].bad      = 1;
          mdl[i].err      = (mdl[i].err < 255) ? mdl[i].err + 1 : 255;
          mdl[i].hasPrev  = 0;
          mdl[i].streak   = 0;
          mdl[i].isLocked = 0;
        end else begin
          mdl[i].vld = 1;
          mdl[i].dig = v;
          if (mdl[i].hasPrev != 0) begin
            expNext = (mdl[i].prev + (mdlDown[i] != 0 ? 7 : 1)) % 8;
            if (mdl[i].isLocked != 0) begin
              if (v != expNext) begin
                mdl[i].seq      = 1;
                mdl[i].err      = (mdl[i].err < 255) ? mdl[i].err + 1 : 255;
                mdl[i].isLocked = 0;
                mdl[i].streak   = 0;
              end
            end else if (v == expNext) begin
              mdl[i].streak++;
              if (mdl[i].streak == mdlLockN[i]) mdl[i].isLocked = 1;
            end else begin
              mdl[i].streak = 0;
            end
          end
          mdl[i].prev    = v;
          mdl[i].hasPrev = 1;
        end
      end
    end
  endtask

  task automatic checkModels(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s.u%0d.digit", tag, i), int'(digit[i]), mdl[i].dig);
      checkOutput($sformatf("%s.u%0d.digit_vld", tag, i), int'(digit_vld[i]), mdl[i].vld);
      checkOutput($sformatf("%s.u%0d.bad_code", tag, i), int'(bad_code[i]), mdl[i].bad);
      checkOutput($sformatf("%s.u%0d.seq_err", tag, i), int'(seq_err[i]), mdl[i].seq);
      checkOutput($sformatf("%s.u%0d.locked", tag, i), int'(locked[i]), mdl[i].isLocked);
      checkOutput($sformatf("%s.u%0d.err_cnt", tag, i), int'(err_cnt[i]), mdl[i].err);
    end
  endtask

  // Called at a negative edge: drive inputs, let one rising edge pass, step
  // the model, then return at the following negative edge with outputs settled.
  task automatic applyStimulus(input logic [6:0] s, input logic stb, input logic rst,
                               input string tag);
    seg_in  = s;
    seg_stb = stb;
    reset   = rst;
    @(posedge clk);
    updateModel(0, s, stb, rst);
    updateModel(1, s, stb, rst);
    @(negedge clk);
    checkModels(tag);
  endtask

  initial begin
    codeTab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    mdlDown  = '{1, 0};
    mdlLockN = '{2, 1};
    mdl[0] = '{default: 0};
    mdl[1] = '{default: 0};
    reset   = 1'b1;
    seg_in  = 7'h00;
    seg_stb = 1'b0;

    // Expected values for the down-counting instance (DOWN=1, LOCK_N=2).
    //                 seg    stb   rst   dig   vld   bad   seq   lck   err
    vecs.push_back('{7'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{7'h78, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{7'h02, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    vecs.push_back('{7'h12, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h30, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h19, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h30, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h24, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h79, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h40, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h78, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h02, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h12, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h19, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0});
    vecs.push_back('{7'h24, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1});
    vecs.push_back('{7'h7F, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{7'h30, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{7'h30, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{7'h24, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2});
    vecs.push_back('{7'h79, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2});
    vecs.push_back('{7'h79, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3});
    vecs.push_back('{7'h40, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

    @(negedge clk);

    $display("[TB] table vectors");
    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n].seg, vecs[n].stb, vecs[n].rst, $sformatf("vec%0d", n));
      checkOutput($sformatf("vec%0d.digit", n), int'(digit[0]), int'(vecs[n].dig));
      checkOutput($sformatf("vec%0d.digit_vld", n), int'(digit_vld[0]), int'(vecs[n].vld));
      checkOutput($sformatf("vec%0d.bad_code", n), int'(bad_code[0]), int'(vecs[n].bad));
      checkOutput($sformatf("vec%0d.seq_err", n), int'(seq_err[0]), int'(vecs[n].seq));
      checkOutput($sformatf("vec%0d.locked", n), int'(locked[0]), int'(vecs[n].lck));
      checkOutput($sformatf("vec%0d.err_cnt", n), int'(err_cnt[0]), int'(vecs[n].err));
    end

    $display("[TB] randomized stimulus");
    for (int n = 0; n < 600; n++) begin
      logic [6:0] s;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5)      s = codeTab[(mdl[0].prev + 7) % 8];
      else if (r < 7) s = codeTab[(mdl[1].prev + 1) % 8];
      else if (r < 9) s = codeTab[$urandom_range(0, 7)];
      else            s = 7'($urandom_range(0, 127));
      applyStimulus(s, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 59) == 0),
                    $sformatf("rnd%0d", n));
    end

    $display("[TB] error counter saturation");
    applyStimulus(7'h00, 1'b0, 1'b1, "satrst");
    for (int n = 0; n < 300; n++) begin
      seg_in  = 7'h7F;
      seg_stb = 1'b1;
      reset   = 1'b0;
      @(posedge clk);
      updateModel(0, 7'h7F, 1'b1, 1'b0);
      updateModel(1, 7'h7F, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("sat.err_cnt.u0", int'(err_cnt[0]), 255);
    checkOutput("sat.err_cnt.u1", int'(err_cnt[1]), 255);
    checkOutput("sat.bad_code.u0", int'(bad_code[0]), 1);
    checkModels("sat");
    applyStimulus(7'h7F, 1'b1, 1'b1, "satclr");
    checkOutput("satclr.err_cnt", int'(err_cnt[0]), 0);
    checkOutput("satclr.locked", int'(locked[0]), 0);
    checkOutput("satclr.digit", int'(digit[0]), 0);
    checkOutput("satclr.bad_code", int'(bad_code[0]), 0);

    $display("[TB] up-count wrap");
    applyStimulus(7'h02, 1'b1, 1'b0, "up6");
    checkOutput("up6.locked", int'(locked[1]), 0);
    applyStimulus(7'h78, 1'b1, 1'b0, "up7");
    checkOutput("up7.locked", int'(locked[1]), 1);
    checkOutput("up7.digit", int'(digit[1]), 7);
    applyStimulus(7'h40, 1'b1, 1'b0, "up0");
    checkOutput("up0.locked", int'(locked[1]), 1);
    checkOutput("up0.seq_err", int'(seq_err[1]), 0);
    checkOutput("up0.digit", int'(digit[1]), 0);
    checkOutput("up0.err_cnt", int'(err_cnt[1]), 0);
    applyStimulus(7'h40, 1'b0, 1'b0, "upidle");
    checkOutput("upidle.digit_vld", int'(digit_vld[1]), 0);
    checkOutput("upidle.locked", int'(locked[1]), 1);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
